// File: rtl/swu_dilated_stream.sv
// Sliding-window unit with kernel dilation. It buffers a raster-order input frame and re-emits
// it as one tap stream per output pixel, in the order (oy, ox, ky, kx, channel fold).
module swu_dilated_stream #(
    parameter int    SIMD      = 2,
    parameter int    IFM_CH    = 4,
    parameter int    IFM_W     = 8,
    parameter int    IFM_H     = 8,
    parameter int    K_W       = 3,
    parameter int    K_H       = 3,
    parameter int    STRIDE    = 1,
    parameter int    DILATION  = 1,
    parameter int    PAD_L     = 1,
    parameter int    PAD_T     = 1,
    parameter int    OFM_W     = 8,
    parameter int    OFM_H     = 8,
    parameter int    PREC      = 4,
    parameter string RAM_STYLE = "auto"
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [SIMD*PREC-1:0] ip_data,
    input  logic                 ip_axis_tvalid,
    output logic                 ip_axis_tready,
    output logic [SIMD*PREC-1:0] op_data,
    output logic                 op_axis_tvalid,
    input  logic                 op_axis_tready
);

    localparam int EFF_CH   = IFM_CH / SIMD;
    localparam int DW       = SIMD * PREC;
    localparam int DEPTH    = (DILATION * (K_H - 1) + 1) * IFM_W * EFF_CH;
    localparam int FRAME_IN = IFM_H * IFM_W * EFF_CH;

    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW  = $clog2(FRAME_IN + 1);
    localparam int OYW = (OFM_H > 1) ? $clog2(OFM_H) : 1;
    localparam int OXW = (OFM_W > 1) ? $clog2(OFM_W) : 1;
    localparam int KYW = (K_H > 1) ? $clog2(K_H) : 1;
    localparam int KXW = (K_W > 1) ? $clog2(K_W) : 1;
    localparam int CHW = (EFF_CH > 1) ? $clog2(EFF_CH) : 1;

    localparam logic [OYW-1:0] OY_MAX    = OYW'(OFM_H - 1);
    localparam logic [OXW-1:0] OX_MAX    = OXW'(OFM_W - 1);
    localparam logic [KYW-1:0] KY_MAX    = KYW'(K_H - 1);
    localparam logic [KXW-1:0] KX_MAX    = KXW'(K_W - 1);
    localparam logic [CHW-1:0] CH_MAX    = CHW'(EFF_CH - 1);
    localparam logic [AW-1:0]  PTR_MAX   = AW'(DEPTH - 1);
    localparam logic [CW-1:0]  FRAME_CNT = CW'(FRAME_IN);

    (* ram_style = RAM_STYLE *) logic [DW-1:0] mem [DEPTH];

    logic [OYW-1:0] oy_q, oy_d;
    logic [OXW-1:0] ox_q, ox_d;
    logic [KYW-1:0] ky_q, ky_d;
    logic [KXW-1:0] kx_q, kx_d;
    logic [CHW-1:0] ch_q, ch_d;
    logic [CW-1:0]  wr_cnt_q, wr_cnt_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic           rd_done_q, rd_done_d;
    logic           op_valid_q, op_valid_d;
    logic           pad_q, pad_d;
    logic           run_q;
    logic [DW-1:0]  rd_q;

    int             iy, ix, iy0, lin, oldest;
    logic           tap_pad, tap_ok, last_tap, issue, wr_fire, wrap;
    logic [AW-1:0]  rd_addr;

    // Source coordinates of the current tap; negative or past-edge values are padding.
    always_comb begin
        iy0     = int'(oy_q) * STRIDE - PAD_T;
        iy      = iy0 + int'(ky_q) * DILATION;
        ix      = int'(ox_q) * STRIDE - PAD_L + int'(kx_q) * DILATION;
        tap_pad = (iy < 0) || (iy >= IFM_H) || (ix < 0) || (ix >= IFM_W);
        lin     = (iy * IFM_W + ix) * EFF_CH + int'(ch_q);
        tap_ok  = tap_pad || (lin < int'(wr_cnt_q));
        rd_addr = tap_pad ? '0 : AW'(lin % DEPTH);
        // Rows above the current window's top row are never read again.
        oldest  = ((iy0 < 0) ? 0 : iy0) * IFM_W * EFF_CH;
    end

    assign last_tap = (oy_q == OY_MAX) && (ox_q == OX_MAX) && (ky_q == KY_MAX) &&
                      (kx_q == KX_MAX) && (ch_q == CH_MAX);

    assign ip_axis_tready = run_q && !rst && (wr_cnt_q != FRAME_CNT) &&
                            (rd_done_q || (int'(wr_cnt_q) < oldest + DEPTH));
    assign wr_fire        = ip_axis_tvalid && ip_axis_tready;
    assign issue          = (!op_valid_q || op_axis_tready) && !rd_done_q && tap_ok;
    assign wrap           = rd_done_q && (wr_cnt_q == FRAME_CNT) &&
                            (!op_valid_q || op_axis_tready);

    always_comb begin
        oy_d       = oy_q;
        ox_d       = ox_q;
        ky_d       = ky_q;
        kx_d       = kx_q;
        ch_d       = ch_q;
        rd_done_d  = rd_done_q;
        wr_cnt_d   = wr_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        op_valid_d = op_valid_q;
        pad_d      = pad_q;

        if (wrap) begin
            oy_d       = '0;
            ox_d       = '0;
            ky_d       = '0;
            kx_d       = '0;
            ch_d       = '0;
            rd_done_d  = 1'b0;
            wr_cnt_d   = '0;
            wr_ptr_d   = '0;
            op_valid_d = 1'b0;
        end else begin
            if (wr_fire) begin
                wr_cnt_d = wr_cnt_q + 1'b1;
                wr_ptr_d = (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + 1'b1;
            end
            if (issue) begin
                op_valid_d = 1'b1;
                pad_d      = tap_pad;
                if (last_tap) begin
                    rd_done_d = 1'b1;
                end else if (ch_q != CH_MAX) begin
                    ch_d = ch_q + 1'b1;
                end else begin
                    ch_d = '0;
                    if (kx_q != KX_MAX) begin
                        kx_d = kx_q + 1'b1;
                    end else begin
                        kx_d = '0;
                        if (ky_q != KY_MAX) begin
                            ky_d = ky_q + 1'b1;
                        end else begin
                            ky_d = '0;
                            if (ox_q != OX_MAX) begin
                                ox_d = ox_q + 1'b1;
                            end else begin
                                ox_d = '0;
                                oy_d = oy_q + 1'b1;
                            end
                        end
                    end
                end
            end else if (op_axis_tready) begin
                op_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            oy_q       <= '0;
            ox_q       <= '0;
            ky_q       <= '0;
            kx_q       <= '0;
            ch_q       <= '0;
            rd_done_q  <= 1'b0;
            wr_cnt_q   <= '0;
            wr_ptr_q   <= '0;
            op_valid_q <= 1'b0;
            pad_q      <= 1'b1;
            run_q      <= 1'b0;
        end else begin
            oy_q       <= oy_d;
            ox_q       <= ox_d;
            ky_q       <= ky_d;
            kx_q       <= kx_d;
            ch_q       <= ch_d;
            rd_done_q  <= rd_done_d;
            wr_cnt_q   <= wr_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            op_valid_q <= op_valid_d;
            pad_q      <= pad_d;
            run_q      <= 1'b1;
        end
    end

    // Buffer storage carries no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr_q] <= ip_data;
        end
        if (issue && !tap_pad) begin
            rd_q <= mem[rd_addr];
        end
    end

    assign op_axis_tvalid = op_valid_q;
    assign op_data        = pad_q ? '0 : rd_q;

endmodule

// File: tb/tb_swu_dilated_stream.sv
// Directed bench for swu_dilated_stream: three configurations (default, dilated, strided)
// driven from one initial block; expected taps come from a coordinate reference function.
module tb_swu_dilated_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst;
    logic [2:0] iv;
    logic [2:0] ir;
    logic [2:0] ov;
    logic [2:0] ordy;
    logic [7:0] ipd [3];
    logic [7:0] opd0, opd1, opd2;

    int checks   = 0;
    int failures = 0;
    logic [7:0] cap [0:2303];

    swu_dilated_stream u_def (
        .clk(clk), .rst(rst[0]), .ip_data(ipd[0]), .ip_axis_tvalid(iv[0]),
        .ip_axis_tready(ir[0]), .op_data(opd0), .op_axis_tvalid(ov[0]),
        .op_axis_tready(ordy[0])
    );

    swu_dilated_stream #(.DILATION(2), .PAD_L(2), .PAD_T(2)) u_dil (
        .clk(clk), .rst(rst[1]), .ip_data(ipd[1]), .ip_axis_tvalid(iv[1]),
        .ip_axis_tready(ir[1]), .op_data(opd1), .op_axis_tvalid(ov[1]),
        .op_axis_tready(ordy[1])
    );

    swu_dilated_stream #(.STRIDE(2), .PAD_L(0), .PAD_T(0), .OFM_W(3), .OFM_H(3)) u_str (
        .clk(clk), .rst(rst[2]), .ip_data(ipd[2]), .ip_axis_tvalid(iv[2]),
        .ip_axis_tready(ir[2]), .op_data(opd2), .op_axis_tvalid(ov[2]),
        .op_axis_tready(ordy[2])
    );

    function automatic logic [7:0] opd_of(input int cfg);
        case (cfg)
            0:       return opd0;
            1:       return opd1;
            default: return opd2;
        endcase
    endfunction

    function automatic int ftotal(input int cfg);
        return (cfg == 2) ? 162 : 1152;
    endfunction

    // Expected tap for beat index within a frame; input beat k carries (base + k).
    function automatic logic [7:0] model(input int cfg, input int beat, input int base);
        int s, d, p, ow, c, kx, ky, ox, oy, t, iy, ix;
        s  = (cfg == 2) ? 2 : 1;
        d  = (cfg == 1) ? 2 : 1;
        p  = (cfg == 0) ? 1 : ((cfg == 1) ? 2 : 0);
        ow = (cfg == 2) ? 3 : 8;
        c  = beat % 2;
        t  = beat / 2;
        kx = t % 3;
        t  = t / 3;
        ky = t % 3;
        t  = t / 3;
        ox = t % ow;
        oy = t / ow;
        iy = oy * s - p + ky * d;
        ix = ox * s - p + kx * d;
        if (iy < 0 || iy > 7 || ix < 0 || ix > 7) return 8'h00;
        return 8'(base + (iy * 8 + ix) * 2 + c);
    endfunction

    function automatic logic rnd(input int pct);
        return (pct >= 100) || (int'($urandom_range(99)) < pct);
    endfunction

    // Streams `frames` frames through one instance, checking every output beat against the
    // model and the hold rule while stalled. stop_after >= 0 ends after that many beats.
    task automatic run_stream(input int cfg, input int frames, input int base, input int in_pct,
                              input int out_pct, input int stop_after, output int got);
        int n_in, n_out, total, ft, limit_in, cyc;
        logic in_hs, out_hs, stalled;
        logic [7:0] held, exp, obs;
        ft       = ftotal(cfg);
        total    = (stop_after >= 0) ? stop_after : frames * ft;
        limit_in = frames * 128;
        n_in     = 0;
        n_out    = 0;
        cyc      = 0;
        stalled  = 1'b0;
        held     = 8'h00;
        @(posedge clk);
        #1;
        iv[cfg]   = rnd(in_pct);
        ipd[cfg]  = 8'(base);
        ordy[cfg] = rnd(out_pct);
        while ((n_out < total || (stop_after < 0 && n_in < limit_in)) && cyc < 20000) begin
            @(negedge clk);
            obs    = opd_of(cfg);
            in_hs  = iv[cfg] & ir[cfg];
            out_hs = ov[cfg] & ordy[cfg];
            if (stalled) begin
                checks++;
                if (ov[cfg] !== 1'b1 || obs !== held) begin
                    failures++;
                    $display("FAIL stall_hold cfg=%0d beat=%0d got valid=%b data=%h want valid=1 data=%h",
                             cfg, n_out, ov[cfg], obs, held);
                end
            end
            stalled = ov[cfg] & ~ordy[cfg];
            held    = obs;
            if (out_hs && n_out < total) begin
                exp        = model(cfg, n_out % ft, base + (n_out / ft) * 128);
                cap[n_out] = obs;
                checks++;
                if (obs !== exp) begin
                    failures++;
                    $display("FAIL stream cfg=%0d beat=%0d got=%h want=%h", cfg, n_out, obs, exp);
                end
                n_out++;
            end
            if (in_hs) n_in++;
            @(posedge clk);
            #1;
            iv[cfg]   = (n_in < limit_in) && rnd(in_pct);
            ipd[cfg]  = 8'(base + n_in);
            ordy[cfg] = rnd(out_pct);
            cyc++;
        end
        if (cyc >= 20000) begin
            checks++;
            failures++;
            $display("FAIL timeout cfg=%0d got beats=%0d inputs=%0d want beats=%0d", cfg, n_out,
                     n_in, total);
        end
        iv[cfg]   = 1'b0;
        ordy[cfg] = 1'b0;
        got       = n_out;
    endtask

    task automatic expect8(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic test_reset();
        rst  = 3'b111;
        iv   = 3'b000;
        ordy = 3'b000;
        for (int i = 0; i < 3; i++) ipd[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        expect8("reset_tvalid", {7'd0, ov[0]}, 8'h00);
        expect8("reset_data", opd0, 8'h00);
        expect8("reset_tready", {7'd0, ir[0]}, 8'h00);
        rst = 3'b000;
        @(posedge clk);
        #1;
        expect8("post_reset_tready", {7'd0, ir[0]}, 8'h01);
        expect8("post_reset_tready_dil", {7'd0, ir[1]}, 8'h01);
    endtask

    task automatic test_defaults_ramp();
        int got;
        run_stream(0, 1, 0, 100, 100, -1, got);
        expect8("ramp_count_lo", 8'(got), 8'(1152));
        checks++;
        if (got != 1152) begin
            failures++;
            $display("FAIL ramp_count got=%0d want=1152", got);
        end
        for (int i = 0; i < 8; i++) expect8("ramp_leading_zero", cap[i], 8'h00);
        expect8("ramp_beat8", cap[8], 8'h00);
        expect8("ramp_beat9", cap[9], 8'h01);
        expect8("ramp_beat10", cap[10], 8'h02);
    endtask

    task automatic test_random_stall();
        int got;
        run_stream(0, 1, 8'h10, 60, 50, -1, got);
        checks++;
        if (got != 1152) begin
            failures++;
            $display("FAIL random_count got=%0d want=1152", got);
        end
    endtask

    task automatic test_back_to_back();
        int got;
        run_stream(0, 2, 8'h80, 100, 100, -1, got);
        checks++;
        if (got != 2304) begin
            failures++;
            $display("FAIL b2b_count got=%0d want=2304", got);
        end
        expect8("b2b_f1_beat9", cap[9], 8'h81);
        expect8("b2b_f2_beat0", cap[1152], 8'h00);
        expect8("b2b_f2_beat9", cap[1161], 8'h01);
    endtask

    task automatic test_reset_mid_frame();
        int got;
        run_stream(0, 1, 8'h33, 100, 100, 300, got);
        rst[0] = 1'b1;
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        expect8("midrst_tvalid", {7'd0, ov[0]}, 8'h00);
        expect8("midrst_data", opd0, 8'h00);
        @(posedge clk);
        #1;
        expect8("midrst_tready", {7'd0, ir[0]}, 8'h01);
        run_stream(0, 1, 8'h40, 100, 100, -1, got);
        checks++;
        if (got != 1152) begin
            failures++;
            $display("FAIL midrst_count got=%0d want=1152", got);
        end
        expect8("midrst_beat9", cap[9], 8'h41);
    endtask

    task automatic test_dilation();
        int got;
        run_stream(1, 1, 5, 100, 100, -1, got);
        checks++;
        if (got != 1152) begin
            failures++;
            $display("FAIL dil_count got=%0d want=1152", got);
        end
        expect8("dil_corner", cap[0], 8'h00);
        expect8("dil_left_pad", cap[6], 8'h00);
        expect8("dil_centre", cap[8], 8'h05);
        expect8("dil_centre_f1", cap[9], 8'h06);
        expect8("dil_right_tap", cap[10], 8'h09);
    endtask

    task automatic test_stride();
        int got, zeros;
        run_stream(2, 1, 1, 80, 70, -1, got);
        checks++;
        if (got != 162) begin
            failures++;
            $display("FAIL stride_count got=%0d want=162", got);
        end
        zeros = 0;
        for (int i = 0; i < 162; i++) if (cap[i] == 8'h00) zeros++;
        checks++;
        if (zeros != 0) begin
            failures++;
            $display("FAIL stride_zero_beats got=%0d want=0", zeros);
        end
        expect8("stride_first", cap[0], 8'h01);
        expect8("stride_win11", cap[72], 8'h25);
        expect8("stride_last", cap[161], 8'h6e);
    endtask

    initial begin
        test_reset();
        test_defaults_ramp();
        test_random_stall();
        test_back_to_back();
        test_reset_mid_frame();
        test_dilation();
        test_stride();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
